// File: rtl/axi_cache_arbiter.sv
// Two-to-one AXI4 master arbiter: I-cache (read-only) and D-cache (read/write)
// share one external master port. One transaction in flight at a time; D-cache
// writebacks win over reads, and tied reads alternate round-robin.
module axi_cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int IC_ID  = 0,
    parameter int DC_ID  = 1,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clock,
    input  logic              rst_n,
    // I-cache AR / R
    input  logic              ic_arvalid,
    output logic              ic_arready,
    input  logic [ADDR_W-1:0] ic_araddr,
    input  logic [7:0]        ic_arlen,
    input  logic [2:0]        ic_arsize,
    input  logic [1:0]        ic_arburst,
    output logic              ic_rvalid,
    input  logic              ic_rready,
    output logic [DATA_W-1:0] ic_rdata,
    output logic [1:0]        ic_rresp,
    output logic              ic_rlast,
    // D-cache AR / R
    input  logic              dc_arvalid,
    output logic              dc_arready,
    input  logic [ADDR_W-1:0] dc_araddr,
    input  logic [7:0]        dc_arlen,
    input  logic [2:0]        dc_arsize,
    input  logic [1:0]        dc_arburst,
    output logic              dc_rvalid,
    input  logic              dc_rready,
    output logic [DATA_W-1:0] dc_rdata,
    output logic [1:0]        dc_rresp,
    output logic              dc_rlast,
    // D-cache AW / W / B
    input  logic              dc_awvalid,
    output logic              dc_awready,
    input  logic [ADDR_W-1:0] dc_awaddr,
    input  logic [7:0]        dc_awlen,
    input  logic [2:0]        dc_awsize,
    input  logic [1:0]        dc_awburst,
    input  logic              dc_wvalid,
    output logic              dc_wready,
    input  logic [DATA_W-1:0] dc_wdata,
    input  logic [STRB_W-1:0] dc_wstrb,
    input  logic              dc_wlast,
    output logic              dc_bvalid,
    input  logic              dc_bready,
    output logic [1:0]        dc_bresp,
    // AXI4 master port
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [ID_W-1:0]   m_awid,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [7:0]        m_awlen,
    output logic [2:0]        m_awsize,
    output logic [1:0]        m_awburst,
    output logic              m_wvalid,
    input  logic              m_wready,
    output logic [DATA_W-1:0] m_wdata,
    output logic [STRB_W-1:0] m_wstrb,
    output logic              m_wlast,
    input  logic              m_bvalid,
    output logic              m_bready,
    input  logic [ID_W-1:0]   m_bid,
    input  logic [1:0]        m_bresp,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ID_W-1:0]   m_arid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [ID_W-1:0]   m_rid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast
);

    typedef enum logic [2:0] {IDLE, I_AR, I_R, D_AR, D_R, D_AW, D_W, D_B} state_t;

    state_t state, state_nxt;
    logic   last_rd;   // 1: D-cache held the most recent read grant

    // Response IDs are not checked: only one transaction is ever outstanding.
    logic unused_ids;
    assign unused_ids = ^{m_rid, m_bid};

    // State register and round-robin memory; reset makes the I-cache win the first tie.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last_rd <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == I_AR)
                last_rd <= 1'b0;
            else if (state == IDLE && state_nxt == D_AR)
                last_rd <= 1'b1;
        end
    end

    // Arbitration, next-state and owner-only channel routing; everything unrouted is 0.
    always_comb begin
        state_nxt  = state;
        m_awvalid  = 1'b0; m_awid  = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
        m_wvalid   = 1'b0; m_wdata = '0; m_wstrb  = '0; m_wlast = 1'b0;
        m_bready   = 1'b0;
        m_arvalid  = 1'b0; m_arid  = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
        m_rready   = 1'b0;
        ic_arready = 1'b0; ic_rvalid = 1'b0; ic_rdata = '0; ic_rresp = '0; ic_rlast = 1'b0;
        dc_arready = 1'b0; dc_rvalid = 1'b0; dc_rdata = '0; dc_rresp = '0; dc_rlast = 1'b0;
        dc_awready = 1'b0; dc_wready = 1'b0; dc_bvalid = 1'b0; dc_bresp = '0;

        case (state)
            IDLE: begin
                if (dc_awvalid)
                    state_nxt = D_AW;
                else if (ic_arvalid && dc_arvalid)
                    state_nxt = last_rd ? I_AR : D_AR;
                else if (ic_arvalid)
                    state_nxt = I_AR;
                else if (dc_arvalid)
                    state_nxt = D_AR;
            end
            I_AR: begin
                m_arvalid  = ic_arvalid;
                m_arid     = ID_W'(IC_ID);
                m_araddr   = ic_araddr;
                m_arlen    = ic_arlen;
                m_arsize   = ic_arsize;
                m_arburst  = ic_arburst;
                ic_arready = m_arready;
                if (ic_arvalid && m_arready) state_nxt = I_R;
            end
            I_R: begin
                ic_rvalid = m_rvalid;
                ic_rdata  = m_rdata;
                ic_rresp  = m_rresp;
                ic_rlast  = m_rlast;
                m_rready  = ic_rready;
                if (m_rvalid && ic_rready && m_rlast) state_nxt = IDLE;
            end
            D_AR: begin
                m_arvalid  = dc_arvalid;
                m_arid     = ID_W'(DC_ID);
                m_araddr   = dc_araddr;
                m_arlen    = dc_arlen;
                m_arsize   = dc_arsize;
                m_arburst  = dc_arburst;
                dc_arready = m_arready;
                if (dc_arvalid && m_arready) state_nxt = D_R;
            end
            D_R: begin
                dc_rvalid = m_rvalid;
                dc_rdata  = m_rdata;
                dc_rresp  = m_rresp;
                dc_rlast  = m_rlast;
                m_rready  = dc_rready;
                if (m_rvalid && dc_rready && m_rlast) state_nxt = IDLE;
            end
            D_AW: begin
                m_awvalid  = dc_awvalid;
                m_awid     = ID_W'(DC_ID);
                m_awaddr   = dc_awaddr;
                m_awlen    = dc_awlen;
                m_awsize   = dc_awsize;
                m_awburst  = dc_awburst;
                dc_awready = m_awready;
                if (dc_awvalid && m_awready) state_nxt = D_W;
            end
            D_W: begin
                m_wvalid  = dc_wvalid;
                m_wdata   = dc_wdata;
                m_wstrb   = dc_wstrb;
                m_wlast   = dc_wlast;
                dc_wready = m_wready;
                if (dc_wvalid && m_wready && dc_wlast) state_nxt = D_B;
            end
            D_B: begin
                dc_bvalid = m_bvalid;
                dc_bresp  = m_bresp;
                m_bready  = dc_bready;
                if (m_bvalid && dc_bready) state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_cache_arbiter.sv
// Self-checking bench for axi_cache_arbiter: a table of arbitration scenarios
// driven against a scripted slave, with a beat scoreboard, plus hand-written
// backpressure and mid-transaction reset sequences.
module tb_axi_cache_arbiter;
    localparam int ADDR_W = 32, DATA_W = 64, ID_W = 4, STRB_W = 8;
    localparam int IC_ID = 0, DC_ID = 1;

    logic clock = 1'b0, rst_n = 1'b0;
    logic ic_arvalid = 0, ic_arready, ic_rvalid, ic_rready = 0, ic_rlast;
    logic [ADDR_W-1:0] ic_araddr = '0;
    logic [7:0] ic_arlen = '0; logic [2:0] ic_arsize = '0; logic [1:0] ic_arburst = '0;
    logic [DATA_W-1:0] ic_rdata; logic [1:0] ic_rresp;
    logic dc_arvalid = 0, dc_arready, dc_rvalid, dc_rready = 0, dc_rlast;
    logic [ADDR_W-1:0] dc_araddr = '0;
    logic [7:0] dc_arlen = '0; logic [2:0] dc_arsize = '0; logic [1:0] dc_arburst = '0;
    logic [DATA_W-1:0] dc_rdata; logic [1:0] dc_rresp;
    logic dc_awvalid = 0, dc_awready;
    logic [ADDR_W-1:0] dc_awaddr = '0;
    logic [7:0] dc_awlen = '0; logic [2:0] dc_awsize = '0; logic [1:0] dc_awburst = '0;
    logic dc_wvalid = 0, dc_wready, dc_wlast = 0;
    logic [DATA_W-1:0] dc_wdata = '0; logic [STRB_W-1:0] dc_wstrb = '0;
    logic dc_bvalid, dc_bready = 0; logic [1:0] dc_bresp;
    logic m_awvalid, m_awready = 0; logic [ID_W-1:0] m_awid; logic [ADDR_W-1:0] m_awaddr;
    logic [7:0] m_awlen; logic [2:0] m_awsize; logic [1:0] m_awburst;
    logic m_wvalid, m_wready = 0, m_wlast; logic [DATA_W-1:0] m_wdata; logic [STRB_W-1:0] m_wstrb;
    logic m_bvalid = 0, m_bready; logic [ID_W-1:0] m_bid = '0; logic [1:0] m_bresp = '0;
    logic m_arvalid, m_arready = 0; logic [ID_W-1:0] m_arid; logic [ADDR_W-1:0] m_araddr;
    logic [7:0] m_arlen; logic [2:0] m_arsize; logic [1:0] m_arburst;
    logic m_rvalid = 0, m_rready, m_rlast = 0; logic [ID_W-1:0] m_rid = '0;
    logic [DATA_W-1:0] m_rdata = '0; logic [1:0] m_rresp = '0;

    always #5 clock = ~clock;

    axi_cache_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .IC_ID(IC_ID), .DC_ID(DC_ID)) dut (
        .clock(clock), .rst_n(rst_n),
        .ic_arvalid(ic_arvalid), .ic_arready(ic_arready), .ic_araddr(ic_araddr), .ic_arlen(ic_arlen),
        .ic_arsize(ic_arsize), .ic_arburst(ic_arburst), .ic_rvalid(ic_rvalid), .ic_rready(ic_rready),
        .ic_rdata(ic_rdata), .ic_rresp(ic_rresp), .ic_rlast(ic_rlast),
        .dc_arvalid(dc_arvalid), .dc_arready(dc_arready), .dc_araddr(dc_araddr), .dc_arlen(dc_arlen),
        .dc_arsize(dc_arsize), .dc_arburst(dc_arburst), .dc_rvalid(dc_rvalid), .dc_rready(dc_rready),
        .dc_rdata(dc_rdata), .dc_rresp(dc_rresp), .dc_rlast(dc_rlast),
        .dc_awvalid(dc_awvalid), .dc_awready(dc_awready), .dc_awaddr(dc_awaddr), .dc_awlen(dc_awlen),
        .dc_awsize(dc_awsize), .dc_awburst(dc_awburst), .dc_wvalid(dc_wvalid), .dc_wready(dc_wready),
        .dc_wdata(dc_wdata), .dc_wstrb(dc_wstrb), .dc_wlast(dc_wlast), .dc_bvalid(dc_bvalid),
        .dc_bready(dc_bready), .dc_bresp(dc_bresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast)
    );

    // grant: 0 = I-cache read, 1 = D-cache read, 2 = D-cache write
    typedef struct { logic ic_v; logic dc_v; logic aw_v; int grant; logic [31:0] addr; int beats; logic [1:0] resp; } vec_t;
    typedef struct { logic [63:0] data; logic [1:0] resp; logic last; } beat_t;

    vec_t  vecs[9];
    beat_t sb[$];
    int n_vec = 0, n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present requests in IDLE (nothing forwarded yet), then advance to the grant cycle.
    task automatic request(input logic icv, input logic dcv, input logic awv, input logic [31:0] addr, input int beats);
        ic_arvalid = icv; ic_araddr = addr;            ic_arlen = 8'(beats-1); ic_arsize = 3'd3; ic_arburst = 2'b01;
        dc_arvalid = dcv; dc_araddr = addr ^ 32'h1000; dc_arlen = 8'(beats-1); dc_arsize = 3'd3; dc_arburst = 2'b01;
        dc_awvalid = awv; dc_awaddr = addr ^ 32'h2000; dc_awlen = 8'(beats-1); dc_awsize = 3'd3; dc_awburst = 2'b01;
        #1;
        chk("idle_arvalid", 64'(m_arvalid), 64'(0));
        chk("idle_awvalid", 64'(m_awvalid), 64'(0));
        @(posedge clock); #1;
    endtask

    // Called in the AR grant cycle; runs AR (with optional stall) and the R burst.
    task automatic do_read(input int who, input logic [31:0] addr, input int beats, input logic [1:0] resp,
                           input int ar_stall, input int rr_stall);
        logic [31:0] a_exp;
        logic rdy, own_v;
        int b, stall, pushed, cyc;
        beat_t e;
        a_exp = (who == 0) ? addr : (addr ^ 32'h1000);
        for (int s = 0; s <= ar_stall; s++) begin
            m_arready = (s == ar_stall);
            #1;
            chk("ar_valid", 64'(m_arvalid), 64'(1));
            chk("ar_id", 64'(m_arid), 64'((who == 0) ? IC_ID : DC_ID));
            chk("ar_addr", 64'(m_araddr), 64'(a_exp));
            chk("ar_len", 64'(m_arlen), 64'(beats-1));
            chk("ar_ready_req", 64'((who == 0) ? ic_arready : dc_arready), 64'(s == ar_stall));
            chk("ar_ready_other", 64'((who == 0) ? dc_arready : ic_arready), 64'(0));
            @(posedge clock); #1;
        end
        ic_arvalid = 0; dc_arvalid = 0; dc_awvalid = 0; m_arready = 0;
        b = 0; stall = 0; pushed = -1; cyc = 0;
        while (b < beats) begin
            rdy = !(b == 1 && stall < rr_stall);
            m_rvalid = 1; m_rdata = {addr, 32'(b)}; m_rresp = resp; m_rlast = (b == beats-1);
            ic_rready = (who == 0) ? rdy : 1'b1;
            dc_rready = (who == 1) ? rdy : 1'b1;
            if (pushed != b) begin
                e.data = m_rdata; e.resp = resp; e.last = m_rlast;
                sb.push_back(e);
                pushed = b;
            end
            #1;
            own_v = (who == 0) ? ic_rvalid : dc_rvalid;
            chk("r_valid_req", 64'(own_v), 64'(1));
            chk("r_valid_other", 64'((who == 0) ? dc_rvalid : ic_rvalid), 64'(0));
            chk("r_ready_m", 64'(m_rready), 64'(rdy));
            if (own_v && rdy && sb.size() > 0) begin
                e = sb.pop_front();
                chk("r_data", (who == 0) ? ic_rdata : dc_rdata, e.data);
                chk("r_resp", 64'((who == 0) ? ic_rresp : dc_rresp), 64'(e.resp));
                chk("r_last", 64'((who == 0) ? ic_rlast : dc_rlast), 64'(e.last));
                b++;
            end else if (!rdy) begin
                stall++;
            end
            cyc++;
            if (cyc > 20) begin
                chk("r_timeout_beats", 64'(b), 64'(beats));
                break;
            end
            @(posedge clock); #1;
        end
        // Slave keeps rvalid high: back in IDLE the R path must be closed.
        ic_rready = 1; dc_rready = 1;
        #1;
        chk("r_closed_ready", 64'(m_rready), 64'(0));
        chk("r_closed_ic", 64'(ic_rvalid), 64'(0));
        chk("r_closed_dc", 64'(dc_rvalid), 64'(0));
        chk("r_sb_empty", 64'(sb.size()), 64'(0));
        sb.delete();
        m_rvalid = 0; m_rlast = 0; ic_rready = 0; dc_rready = 0;
    endtask

    // Called in the D_AW grant cycle; runs AW, the W burst and the B response.
    task automatic do_write(input logic [31:0] addr, input int beats, input logic [1:0] bresp);
        beat_t e;
        m_awready = 1; m_wready = 1;
        dc_wvalid = 1; dc_wdata = {addr, 32'h0}; dc_wstrb = '1; dc_wlast = (beats == 1);
        #1;
        chk("aw_valid", 64'(m_awvalid), 64'(1));
        chk("aw_id", 64'(m_awid), 64'(DC_ID));
        chk("aw_addr", 64'(m_awaddr), 64'(addr ^ 32'h2000));
        chk("aw_len", 64'(m_awlen), 64'(beats-1));
        chk("aw_ready_req", 64'(dc_awready), 64'(1));
        chk("w_before_aw", 64'(m_wvalid), 64'(0));
        chk("w_ready_before_aw", 64'(dc_wready), 64'(0));
        chk("ar_during_write", 64'(m_arvalid), 64'(0));
        @(posedge clock); #1;
        dc_awvalid = 0; ic_arvalid = 0; dc_arvalid = 0; m_awready = 0;
        for (int b = 0; b < beats; b++) begin
            dc_wdata = {addr, 32'(b)}; dc_wlast = (b == beats-1);
            e.data = dc_wdata; e.resp = 2'b00; e.last = dc_wlast;
            sb.push_back(e);
            #1;
            chk("w_valid", 64'(m_wvalid), 64'(1));
            chk("w_ready_req", 64'(dc_wready), 64'(1));
            chk("aw_off_in_w", 64'(m_awvalid), 64'(0));
            if (m_wvalid && m_wready) begin
                e = sb.pop_front();
                chk("w_data", m_wdata, e.data);
                chk("w_strb", 64'(m_wstrb), 64'hFF);
                chk("w_last", 64'(m_wlast), 64'(e.last));
            end
            @(posedge clock); #1;
        end
        dc_wvalid = 0; dc_wlast = 0; m_wready = 0;
        m_bvalid = 1; m_bresp = bresp; dc_bready = 1;
        #1;
        chk("b_valid_req", 64'(dc_bvalid), 64'(1));
        chk("b_resp", 64'(dc_bresp), 64'(bresp));
        chk("b_ready_m", 64'(m_bready), 64'(1));
        @(posedge clock); #1;
        #1;
        chk("b_closed", 64'(dc_bvalid), 64'(0));
        chk("w_sb_empty", 64'(sb.size()), 64'(0));
        sb.delete();
        m_bvalid = 0; dc_bready = 0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 0, 32'h8000_0000, 2, 2'd0};  // first tie after reset -> I
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1, 32'h8000_0100, 2, 2'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 0, 32'h8000_0200, 1, 2'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 2, 32'h8000_0300, 2, 2'd0};  // write wins, last_rd stays I
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1, 32'h8000_0400, 4, 2'd0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 2, 32'h8000_0500, 1, 2'd0};  // write wins, last_rd stays D
        vecs[6] = '{1'b1, 1'b1, 1'b0, 0, 32'h8000_0600, 2, 2'd0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1, 32'h8000_0700, 2, 2'd2};  // SLVERR passes through
        vecs[8] = '{1'b1, 1'b0, 1'b0, 0, 32'h8000_0000, 2, 2'd0};

        // Reset state: requests present, nothing forwarded or acknowledged.
        ic_arvalid = 1; dc_awvalid = 1; m_arready = 1; m_awready = 1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_m_arvalid", 64'(m_arvalid), 64'(0));
        chk("rst_m_awvalid", 64'(m_awvalid), 64'(0));
        chk("rst_ic_arready", 64'(ic_arready), 64'(0));
        chk("rst_dc_awready", 64'(dc_awready), 64'(0));
        ic_arvalid = 0; dc_awvalid = 0; m_arready = 0; m_awready = 0;
        @(posedge clock); #1;
        rst_n = 1;
        @(posedge clock); #1;

        for (int i = 0; i < 9; i++) begin
            request(vecs[i].ic_v, vecs[i].dc_v, vecs[i].aw_v, vecs[i].addr, vecs[i].beats);
            if (vecs[i].grant == 2)
                do_write(vecs[i].addr, vecs[i].beats, 2'b00);
            else
                do_read(vecs[i].grant, vecs[i].addr, vecs[i].beats, vecs[i].resp, 0, 0);
            @(posedge clock); #1;
        end

        // Backpressure: arready low for 5 cycles, then rready low for 3 cycles mid-burst.
        request(1'b1, 1'b0, 1'b0, 32'h8000_0040, 4);
        do_read(0, 32'h8000_0040, 4, 2'd0, 5, 3);
        @(posedge clock); #1;

        // Reset asserted during D_W: everything drops at once, then a fresh I-cache read.
        request(1'b0, 1'b0, 1'b1, 32'h8000_0800, 2);
        m_awready = 1;
        #1;
        chk("rstw_aw_valid", 64'(m_awvalid), 64'(1));
        @(posedge clock); #1;
        dc_awvalid = 0; m_awready = 0;
        dc_wvalid = 1; dc_wdata = 64'hDEAD_BEEF_0000_0001; dc_wstrb = '1; dc_wlast = 0; m_wready = 1;
        ic_arvalid = 1; ic_araddr = 32'h8000_0900;
        #1;
        chk("rstw_w_valid", 64'(m_wvalid), 64'(1));
        rst_n = 0;
        #1;
        chk("rstw_w_drop", 64'(m_wvalid), 64'(0));
        chk("rstw_wready_drop", 64'(dc_wready), 64'(0));
        chk("rstw_ar_idle", 64'(m_arvalid), 64'(0));
        chk("rstw_aw_idle", 64'(m_awvalid), 64'(0));
        dc_wvalid = 0; m_wready = 0; ic_arvalid = 0;
        @(posedge clock); #1;
        rst_n = 1;
        @(posedge clock); #1;
        request(1'b1, 1'b0, 1'b0, 32'h8000_0000, 2);
        do_read(0, 32'h8000_0000, 2, 2'd0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
